// File: rtl/fir_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fir_cfg_pkg
//  Brief    : Shared types, default widths and helper functions for the FIR
//             configuration reload controller.
//  Revision : 1.0 - initial release
// ============================================================================
package fir_cfg_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_t;

  // Default geometry
  localparam int DEF_NUM_CH      = 2;
  localparam int DEF_BAND_W      = 16;
  localparam int DEF_SEL_W       = 2;
  localparam int DEF_HOLD_CYCLES = 4;

  // Upper bound on channel count; the priority encoder works on this width
  localparam int MAX_CH = 8;

  // Channel index width: clog2 of the channel count, never narrower than 1
  function automatic int CH_IDX_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index of the lowest set bit; 0 when nothing is set
  function automatic int lowest_set(input logic [MAX_CH-1:0] v);
    int idx;
    idx = 0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_ch_cfg_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : fir_ch_cfg_cmp
//  Brief    : Single-channel inequality of a {bandlow, bandhi, select} triple
//             against a reference triple.
//  Revision : 1.0 - initial release
// ============================================================================
module fir_ch_cfg_cmp #(
  parameter int BAND_W = 16,
  parameter int SEL_W  = 2
) (
  input  logic [BAND_W-1:0] a_bl_i,
  input  logic [BAND_W-1:0] a_bh_i,
  input  logic [SEL_W-1:0]  a_sel_i,
  input  logic [BAND_W-1:0] b_bl_i,
  input  logic [BAND_W-1:0] b_bh_i,
  input  logic [SEL_W-1:0]  b_sel_i,
  output logic              diff_o
);

  // Any field differing marks the channel as changed
  assign diff_o = (a_bl_i != b_bl_i) || (a_bh_i != b_bh_i) || (a_sel_i != b_sel_i);

endmodule
`default_nettype wire

// File: rtl/fir_cfg_reload_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fir_cfg_reload_ctrl
//  Brief    : Multi-channel FIR configuration change controller. Debounces
//             live band/select changes, commits one channel at a time and
//             handshakes a coefficient reload with the filter core.
//  Revision : 1.0 - initial release
// ============================================================================
module fir_cfg_reload_ctrl
  import fir_cfg_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int BAND_W      = DEF_BAND_W,
  parameter int SEL_W       = DEF_SEL_W,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH*BAND_W-1:0]      bandlow_i,
  input  logic [NUM_CH*BAND_W-1:0]      bandhi_i,
  input  logic [NUM_CH*SEL_W-1:0]       filter_select_i,
  input  logic                          reload_ack,
  output logic [NUM_CH*BAND_W-1:0]      bandlow_o,
  output logic [NUM_CH*BAND_W-1:0]      bandhi_o,
  output logic [NUM_CH*SEL_W-1:0]       filter_select_o,
  output logic                          reload_req,
  output logic [CH_IDX_W(NUM_CH)-1:0]   reload_ch,
  output logic [NUM_CH-1:0]             pending,
  output logic                          busy
);

  localparam int CW    = CH_IDX_W(NUM_CH);
  localparam int BW    = NUM_CH * BAND_W;
  localparam int SW    = NUM_CH * SEL_W;
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           state_q,    state_d;
  logic [BW-1:0]    snap_bl_q,  snap_bl_d;
  logic [BW-1:0]    snap_bh_q,  snap_bh_d;
  logic [SW-1:0]    snap_sel_q, snap_sel_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [BW-1:0]    com_bl_q,   com_bl_d;
  logic [BW-1:0]    com_bh_q,   com_bh_d;
  logic [SW-1:0]    com_sel_q,  com_sel_d;
  logic             req_q,      req_d;
  logic [CW-1:0]    ch_q,       ch_d;

  logic [NUM_CH-1:0] snap_diff;
  logic [MAX_CH-1:0] snap_diff_pad;
  logic              live_chg;
  int                commit_idx;

  // Two comparators per channel: live vs committed, snapshot vs committed
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fir_ch_cfg_cmp #(.BAND_W(BAND_W), .SEL_W(SEL_W)) u_live_cmp (
      .a_bl_i  (bandlow_i[c*BAND_W +: BAND_W]),
      .a_bh_i  (bandhi_i[c*BAND_W +: BAND_W]),
      .a_sel_i (filter_select_i[c*SEL_W +: SEL_W]),
      .b_bl_i  (com_bl_q[c*BAND_W +: BAND_W]),
      .b_bh_i  (com_bh_q[c*BAND_W +: BAND_W]),
      .b_sel_i (com_sel_q[c*SEL_W +: SEL_W]),
      .diff_o  (pending[c])
    );
    fir_ch_cfg_cmp #(.BAND_W(BAND_W), .SEL_W(SEL_W)) u_snap_cmp (
      .a_bl_i  (snap_bl_q[c*BAND_W +: BAND_W]),
      .a_bh_i  (snap_bh_q[c*BAND_W +: BAND_W]),
      .a_sel_i (snap_sel_q[c*SEL_W +: SEL_W]),
      .b_bl_i  (com_bl_q[c*BAND_W +: BAND_W]),
      .b_bh_i  (com_bh_q[c*BAND_W +: BAND_W]),
      .b_sel_i (com_sel_q[c*SEL_W +: SEL_W]),
      .diff_o  (snap_diff[c])
    );
  end

  // Any live field moving away from the snapshot restarts the debounce
  assign live_chg = (bandlow_i != snap_bl_q) || (bandhi_i != snap_bh_q) ||
                    (filter_select_i != snap_sel_q);

  assign snap_diff_pad = MAX_CH'(snap_diff);
  assign commit_idx    = lowest_set(snap_diff_pad);

  // State and datapath registers; reset is asynchronous so req drops at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      snap_bl_q  <= '0;
      snap_bh_q  <= '0;
      snap_sel_q <= '0;
      cnt_q      <= '0;
      com_bl_q   <= '0;
      com_bh_q   <= '0;
      com_sel_q  <= '0;
      req_q      <= 1'b0;
      ch_q       <= '0;
    end else begin
      state_q    <= state_d;
      snap_bl_q  <= snap_bl_d;
      snap_bh_q  <= snap_bh_d;
      snap_sel_q <= snap_sel_d;
      cnt_q      <= cnt_d;
      com_bl_q   <= com_bl_d;
      com_bh_q   <= com_bh_d;
      com_sel_q  <= com_sel_d;
      req_q      <= req_d;
      ch_q       <= ch_d;
    end
  end

  // Next-state: debounce in SETTLE, commit lowest changed channel, await ack
  always_comb begin
    state_d    = state_q;
    snap_bl_d  = snap_bl_q;
    snap_bh_d  = snap_bh_q;
    snap_sel_d = snap_sel_q;
    cnt_d      = cnt_q;
    com_bl_d   = com_bl_q;
    com_bh_d   = com_bh_q;
    com_sel_d  = com_sel_q;
    req_d      = req_q;
    ch_d       = ch_q;

    case (state_q)
      ST_IDLE: begin
        if (|pending) begin
          state_d    = ST_SETTLE;
          snap_bl_d  = bandlow_i;
          snap_bh_d  = bandhi_i;
          snap_sel_d = filter_select_i;
          cnt_d      = CNT_LOAD;
        end
      end

      ST_SETTLE: begin
        if (live_chg) begin
          snap_bl_d  = bandlow_i;
          snap_bh_d  = bandhi_i;
          snap_sel_d = filter_select_i;
          cnt_d      = CNT_LOAD;
        end else if (!(|snap_diff)) begin
          // Inputs settled back onto the committed values: nothing to reload
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (c == commit_idx) begin
              com_bl_d[c*BAND_W +: BAND_W] = snap_bl_q[c*BAND_W +: BAND_W];
              com_bh_d[c*BAND_W +: BAND_W] = snap_bh_q[c*BAND_W +: BAND_W];
              com_sel_d[c*SEL_W +: SEL_W]  = snap_sel_q[c*SEL_W +: SEL_W];
            end
          end
          ch_d    = CW'(commit_idx);
          req_d   = 1'b1;
          state_d = ST_WAIT_ACK;
        end
      end

      ST_WAIT_ACK: begin
        if (reload_ack) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bandlow_o       = com_bl_q;
  assign bandhi_o        = com_bh_q;
  assign filter_select_o = com_sel_q;
  assign reload_req      = req_q;
  assign reload_ch       = ch_q;
  assign busy            = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fir_cfg_reload_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_cfg_reload_ctrl
//  Brief    : Self-checking bench for fir_cfg_reload_ctrl with a scoreboard of
//             expected commits popped on each rising reload request.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fir_cfg_reload_ctrl;

  localparam int NUM_CH = 2;
  localparam int BAND_W = 16;
  localparam int SEL_W  = 2;
  localparam int HOLD   = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH*BAND_W-1:0] bandlow_i, bandhi_i;
  logic [NUM_CH*SEL_W-1:0]  filter_select_i;
  logic                     reload_ack;
  logic [NUM_CH*BAND_W-1:0] bandlow_o, bandhi_o;
  logic [NUM_CH*SEL_W-1:0]  filter_select_o;
  logic                     reload_req;
  logic [0:0]               reload_ch;
  logic [NUM_CH-1:0]        pending;
  logic                     busy;

  typedef struct {
    int          ch;
    logic [15:0] bl;
    logic [15:0] bh;
    logic [1:0]  sel;
    int          cyc;   // expected cycle of the rising request, -1 = any
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   k;
  bit   prev_req = 1'b0;
  bit   had_prev = 1'b0;
  int   low_cnt  = 0;

  fir_cfg_reload_ctrl #(
    .NUM_CH(NUM_CH), .BAND_W(BAND_W), .SEL_W(SEL_W), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .bandlow_i       (bandlow_i),
    .bandhi_i        (bandhi_i),
    .filter_select_i (filter_select_i),
    .reload_ack      (reload_ack),
    .bandlow_o       (bandlow_o),
    .bandhi_o        (bandhi_o),
    .filter_select_o (filter_select_o),
    .reload_req      (reload_req),
    .reload_ch       (reload_ch),
    .pending         (pending),
    .busy            (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] bl_o(input int c);
    return bandlow_o[c*BAND_W +: BAND_W];
  endfunction
  function automatic logic [15:0] bh_o(input int c);
    return bandhi_o[c*BAND_W +: BAND_W];
  endfunction
  function automatic logic [1:0] sel_o(input int c);
    return filter_select_o[c*SEL_W +: SEL_W];
  endfunction

  function automatic exp_t mk(input int ch, input logic [15:0] bl, input logic [15:0] bh,
                              input logic [1:0] sel, input int c);
    exp_t e;
    e.ch = ch; e.bl = bl; e.bh = bh; e.sel = sel; e.cyc = c;
    return e;
  endfunction

  // Monitor: pop an expected commit on every rising request, check spacing
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 1'b0;
        had_prev = 1'b0;
        low_cnt  = 0;
      end else begin
        if (reload_req && !prev_req) begin
          if (had_prev) check("req_low_gap_ok", 32'(low_cnt >= HOLD + 1), 32'd1);
          if (sb.size() == 0) begin
            check("unexpected_req", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("reload_ch", 32'(reload_ch), 32'(e.ch));
            check("commit_bandlow", 32'(bl_o(e.ch)), 32'(e.bl));
            check("commit_bandhi", 32'(bh_o(e.ch)), 32'(e.bh));
            check("commit_select", 32'(sel_o(e.ch)), 32'(e.sel));
            if (e.cyc >= 0) check("req_cycle", 32'(cyc), 32'(e.cyc));
          end
          had_prev = 1'b1;
        end
        if (!reload_req) low_cnt++;
        else low_cnt = 0;
        prev_req = reload_req;
      end
    end
  end

  task automatic wait_req(input int budget);
    int n;
    n = 0;
    while (!reload_req && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!reload_req) check("req_timeout", 32'd0, 32'd1);
  endtask

  // Raise ack dly cycles later; the edge that samples it must drop the request
  task automatic do_ack(input int dly);
    repeat (dly) @(posedge clk);
    #1 reload_ack = 1'b1;
    @(posedge clk);
    #1 reload_ack = 1'b0;
    check("req_fall_on_ack", 32'(reload_req), 32'd0);
    check("idle_after_ack", 32'(busy), 32'd0);
  endtask

  task automatic apply_reset();
    bandlow_i = '0; bandhi_i = '0; filter_select_i = '0; reload_ack = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    reset = 1'b1;
    bandlow_i = '0; bandhi_i = '0; filter_select_i = '0; reload_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // 1: reset state
    check("rst_bandlow", 32'(bandlow_o), 32'd0);
    check("rst_bandhi", 32'(bandhi_o), 32'd0);
    check("rst_select", 32'(filter_select_o), 32'd0);
    check("rst_req", 32'(reload_req), 32'd0);
    check("rst_ch", 32'(reload_ch), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // 2: simple change on ch0, ack two cycles after request
    @(posedge clk); #1 bandlow_i[15:0] = 16'h0100; k = cyc;
    sb.push_back(mk(0, 16'h0100, 16'h0000, 2'b00, k + HOLD + 1));
    #1 check("t2_pending", 32'(pending), 32'h1);
    wait_req(20);
    check("t2_busy", 32'(busy), 32'd1);
    do_ack(2);
    check("t2_pending_clear", 32'(pending), 32'd0);
    check("t2_bandlow", 32'(bl_o(0)), 32'h0100);

    // 3: change again mid-debounce, only the final value commits
    apply_reset();
    @(posedge clk); #1 bandlow_i[15:0] = 16'h0100; k = cyc;
    repeat (2) @(posedge clk);
    #1 bandlow_i[15:0] = 16'h0200;
    sb.push_back(mk(0, 16'h0200, 16'h0000, 2'b00, k + 2 + HOLD + 1));
    wait_req(20);
    do_ack(1);

    // 4: two channels change together, committed one per request
    @(posedge clk); #1 filter_select_i[1:0] = 2'b01; bandhi_i[31:16] = 16'h7FFF; k = cyc;
    sb.push_back(mk(0, 16'h0200, 16'h0000, 2'b01, k + HOLD + 1));
    sb.push_back(mk(1, 16'h0000, 16'h7FFF, 2'b00, -1));
    wait_req(20);
    check("t4_ch1_untouched", 32'(bh_o(1)), 32'd0);
    check("t4_pending_ch1", 32'(pending), 32'h2);
    do_ack(2);
    wait_req(30);
    check("t4_ch0_kept", 32'(sel_o(0)), 32'h1);
    do_ack(0);
    check("t4_pending_clear", 32'(pending), 32'd0);

    // 5: change then revert before commit -> no request
    apply_reset();
    @(posedge clk); #1 bandhi_i[31:16] = 16'h0010;
    repeat (2) @(posedge clk);
    #1 bandhi_i[31:16] = 16'h0000;
    check("t5_busy_settle", 32'(busy), 32'd1);
    repeat (4) @(negedge clk);
    check("t5_back_idle", 32'(busy), 32'd0);
    repeat (8) @(negedge clk);
    check("t5_no_req", 32'(reload_req), 32'd0);
    check("t5_bandhi", 32'(bandhi_o), 32'd0);
    check("t5_pending", 32'(pending), 32'd0);

    // 6: asynchronous reset while waiting for ack
    @(posedge clk); #1 bandlow_i[15:0] = 16'h1234; k = cyc;
    sb.push_back(mk(0, 16'h1234, 16'h0000, 2'b00, k + HOLD + 1));
    wait_req(20);
    @(posedge clk); #3 reset = 1'b1;
    #1;
    check("t6_req_drop", 32'(reload_req), 32'd0);
    check("t6_bandlow_clr", 32'(bandlow_o), 32'd0);
    check("t6_busy_clr", 32'(busy), 32'd0);
    check("t6_pending", 32'(pending), 32'h1);
    @(posedge clk); #1 reset = 1'b0; k = cyc;
    sb.push_back(mk(0, 16'h1234, 16'h0000, 2'b00, k + HOLD + 1));
    @(posedge clk); #1 check("t6_resettle", 32'(busy), 32'd1);
    wait_req(20);
    do_ack(1);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
